// File: rtl/wb_pkg.sv
// Shared writeback-select encodings, one-hot source flags, FSM state type and default load timeout.
package wb_pkg;

    localparam logic [2:0] SEL_ALU   = 3'b000;
    localparam logic [2:0] SEL_LOAD  = 3'b001;
    localparam logic [2:0] SEL_PC4   = 3'b010;
    localparam logic [2:0] SEL_PCIMM = 3'b011;
    localparam logic [2:0] SEL_IMM   = 3'b100;

    localparam logic [4:0] OH_NONE  = 5'b00000;
    localparam logic [4:0] OH_ALU   = 5'b00001;
    localparam logic [4:0] OH_LOAD  = 5'b00010;
    localparam logic [4:0] OH_PC4   = 5'b00100;
    localparam logic [4:0] OH_PCIMM = 5'b01000;
    localparam logic [4:0] OH_IMM   = 5'b10000;

    localparam int MEM_TIMEOUT_DEF = 16;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_sel_onehot.sv
// Combinational 3-to-5 writeback-source decoder; codes above IMM decode to all-zero and raise o_illegal.
module wb_sel_onehot
    import wb_pkg::*;
(
    input  logic [2:0] i_sel,
    output logic [4:0] o_onehot,
    output logic       o_illegal
);

    always_comb begin
        o_onehot  = OH_NONE;
        o_illegal = 1'b0;
        case (i_sel)
            SEL_ALU:   o_onehot = OH_ALU;
            SEL_LOAD:  o_onehot = OH_LOAD;
            SEL_PC4:   o_onehot = OH_PC4;
            SEL_PCIMM: o_onehot = OH_PCIMM;
            SEL_IMM:   o_onehot = OH_IMM;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_sel_decode.sv
// Writeback select/decode stage: one register-file write per accepted request, loads wait for mem_rvalid.
// Optional load timeout (mem_timeout port + counter) is built when WB_MEM_TIMEOUT_EN is defined.
module wb_sel_decode
    import wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_sel,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] pc_plus_imm,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
`ifdef WB_MEM_TIMEOUT_EN
    output logic            mem_timeout,
`endif
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [4:0]      sel_onehot,
    output logic            illegal_sel
);

    wb_state_e       r_state;
    logic            r_rf_we;
    logic [4:0]      r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;
    logic [4:0]      r_sel_onehot;
    logic            r_illegal;
    logic [4:0]      r_ld_rd;
    logic            r_ld_we;

    logic [4:0]      w_onehot;
    logic            w_illegal;
    logic            w_accept;
    logic            w_wr_en;
    logic            w_ld_wr_en;
    logic [XLEN-1:0] w_src;

`ifdef WB_MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
    logic [7:0] r_tmo_cnt;
    logic       r_mem_timeout;
    assign mem_timeout = r_mem_timeout;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = |8'(MEM_TIMEOUT);
`endif

    wb_sel_onehot u_sel_onehot (
        .i_sel     (in_sel),
        .o_onehot  (w_onehot),
        .o_illegal (w_illegal)
    );

    assign in_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_wr_en    = in_reg_write && (in_rd != 5'd0);
    assign w_ld_wr_en = r_ld_we && (r_ld_rd != 5'd0);

    // LOAD has no source at acceptance; its data arrives later on mem_rdata.
    always_comb begin
        w_src = '0;
        case (in_sel)
            SEL_ALU:   w_src = alu_result;
            SEL_PC4:   w_src = pc_plus4;
            SEL_PCIMM: w_src = pc_plus_imm;
            SEL_IMM:   w_src = imm;
            default:   w_src = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_sel_onehot <= OH_NONE;
            r_illegal    <= 1'b0;
            r_ld_rd      <= '0;
            r_ld_we      <= 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_mem_timeout <= 1'b0;
`endif
        end else begin
            r_rf_we   <= 1'b0;
            r_illegal <= 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
            r_mem_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel_onehot <= w_onehot;
                        if (w_illegal) begin
                            r_illegal <= 1'b1;
                        end else if (w_onehot == OH_LOAD) begin
                            r_state <= ST_WAIT_MEM;
                            r_ld_rd <= in_rd;
                            r_ld_we <= in_reg_write;
`ifdef WB_MEM_TIMEOUT_EN
                            r_tmo_cnt <= '0;
`endif
                        end else begin
                            r_rf_we <= w_wr_en;
                            if (w_wr_en) begin
                                r_rf_waddr <= in_rd;
                                r_rf_wdata <= w_src;
                            end
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    // A return on the expiry cycle still completes the load.
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                        r_rf_we <= w_ld_wr_en;
                        if (w_ld_wr_en) begin
                            r_rf_waddr <= r_ld_rd;
                            r_rf_wdata <= mem_rdata;
                        end
`ifdef WB_MEM_TIMEOUT_EN
                        r_tmo_cnt <= '0;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_state       <= ST_IDLE;
                        r_mem_timeout <= 1'b1;
                        r_tmo_cnt     <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign sel_onehot  = r_sel_onehot;
    assign illegal_sel = r_illegal;

endmodule

// File: tb/tb_wb_sel_decode.sv
// Bench for wb_sel_decode: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model (timeout checks when WB_MEM_TIMEOUT_EN is defined).
module tb_wb_sel_decode;
    localparam int XLEN = 32;
    localparam int TMO  = 16;
`ifdef WB_MEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_sel = '0;
    logic [4:0]      in_rd = '0;
    logic            in_reg_write = 1'b0;
    logic [XLEN-1:0] alu_result = '0, pc_plus4 = '0, pc_plus_imm = '0, imm = '0, mem_rdata = '0;
    logic            mem_rvalid = 1'b0;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      sel_onehot;
    logic            illegal_sel;
    logic            mem_timeout;

    wb_sel_decode #(.XLEN(XLEN), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .alu_result(alu_result), .pc_plus4(pc_plus4), .pc_plus_imm(pc_plus_imm), .imm(imm),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
`ifdef WB_MEM_TIMEOUT_EN
        .mem_timeout(mem_timeout),
`endif
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sel_onehot(sel_onehot), .illegal_sel(illegal_sel)
    );
`ifndef WB_MEM_TIMEOUT_EN
    assign mem_timeout = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit              m_live = 0;
    bit              m_waiting = 0;
    int              m_wait_cycles = 0;
    logic [4:0]      m_ld_rd = '0;
    logic            m_ld_we = 1'b0;
    logic            m_we = 1'b0, m_ill = 1'b0, m_tmo = 1'b0;
    logic [4:0]      m_waddr = '0, m_sel = '0;
    logic [XLEN-1:0] m_wdata = '0;

    function automatic logic [XLEN-1:0] source_of(input logic [2:0] code);
        logic [XLEN-1:0] srcs [5];
        srcs = '{alu_result, '0, pc_plus4, pc_plus_imm, imm};
        return srcs[code];
    endfunction

    always @(posedge clk) begin
        logic [4:0] one;
        one = 5'b00001;
        m_live = 1;
        m_we = 1'b0; m_ill = 1'b0; m_tmo = 1'b0;
        if (rst) begin
            m_waiting = 0; m_wait_cycles = 0;
            m_sel = '0; m_waddr = '0; m_wdata = '0;
        end else if (!m_waiting) begin
            if (in_valid) begin
                if (in_sel > 3'd4) begin
                    m_sel = '0;
                    m_ill = 1'b1;
                end else begin
                    m_sel = one << in_sel;
                    if (in_sel == 3'd1) begin
                        m_waiting = 1; m_wait_cycles = 0;
                        m_ld_rd = in_rd; m_ld_we = in_reg_write;
                    end else if (in_reg_write && in_rd != 0) begin
                        m_we = 1'b1; m_waddr = in_rd; m_wdata = source_of(in_sel);
                    end
                end
            end
        end else begin
            m_wait_cycles++;
            if (mem_rvalid) begin
                m_waiting = 0;
                if (m_ld_we && m_ld_rd != 0) begin
                    m_we = 1'b1; m_waddr = m_ld_rd; m_wdata = mem_rdata;
                end
            end else if (TMO_EN && m_wait_cycles == TMO) begin
                m_waiting = 0;
                m_tmo = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_rf_we",    64'(rf_we),       64'(m_we));
            chk("m_rf_waddr", 64'(rf_waddr),    64'(m_waddr));
            chk("m_rf_wdata", 64'(rf_wdata),    64'(m_wdata));
            chk("m_sel",      64'(sel_onehot),  64'(m_sel));
            chk("m_illegal",  64'(illegal_sel), 64'(m_ill));
            chk("m_ready",    64'(in_ready),    64'(!m_waiting && !rst));
            chk("m_timeout",  64'(mem_timeout), 64'(m_tmo));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic v, input logic [2:0] s, input logic [4:0] rd, input logic rw);
        in_valid = v; in_sel = s; in_rd = rd; in_reg_write = rw;
    endtask

    initial begin
        tick(); tick();
        chk("rst_we", 64'(rf_we), 0);
        chk("rst_sel", 64'(sel_onehot), 0);
        chk("rst_waddr", 64'(rf_waddr), 0);
        chk("rst_wdata", 64'(rf_wdata), 0);
        chk("rst_ill", 64'(illegal_sel), 0);
        chk("rst_ready", 64'(in_ready), 0);
        rst = 1'b0;
        #1 chk("post_rst_ready", 64'(in_ready), 1);

        // ALU write
        req(1, 3'b000, 5'd5, 1); alu_result = 32'h0000_1234;
        tick();
        chk("alu_we", 64'(rf_we), 1);
        chk("alu_waddr", 64'(rf_waddr), 5);
        chk("alu_wdata", 64'(rf_wdata), 64'h1234);
        chk("alu_sel", 64'(sel_onehot), 64'b00001);

        // back-to-back IMM then PC+4
        req(1, 3'b100, 5'd3, 1); imm = 32'hFFFF_F000;
        chk("b2b_ready0", 64'(in_ready), 1);
        tick();
        chk("imm_we", 64'(rf_we), 1);
        chk("imm_wdata", 64'(rf_wdata), 64'hFFFF_F000);
        chk("b2b_ready1", 64'(in_ready), 1);
        req(1, 3'b010, 5'd3, 1); pc_plus4 = 32'h104;
        tick();
        chk("pc4_we", 64'(rf_we), 1);
        chk("pc4_wdata", 64'(rf_wdata), 64'h104);
        chk("pc4_sel", 64'(sel_onehot), 64'b00100);
        req(0, 3'b000, 5'd0, 0);
        tick();
        chk("idle_no_we", 64'(rf_we), 0);
        chk("hold_wdata", 64'(rf_wdata), 64'h104);

        // LOAD rd=7 with a stale return on the acceptance cycle, data on the 3rd wait cycle
        req(1, 3'b001, 5'd7, 1); mem_rvalid = 1; mem_rdata = 32'h0000_0BAD;
        tick();
        mem_rvalid = 0;
        chk("ld_stale_we", 64'(rf_we), 0);
        chk("ld_wait1", 64'(in_ready), 0);
        tick();
        chk("ld_wait2", 64'(in_ready), 0);
        tick();
        chk("ld_wait3", 64'(in_ready), 0);
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; req(0, 3'b000, 5'd0, 0);
        tick();
        mem_rvalid = 0;
        chk("ld_we", 64'(rf_we), 1);
        chk("ld_waddr", 64'(rf_waddr), 7);
        chk("ld_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        chk("ld_sel", 64'(sel_onehot), 64'b00010);
        chk("ld_ready", 64'(in_ready), 1);

        // illegal code, then rd=0 write suppression; a stale return in IDLE is ignored
        req(1, 3'b110, 5'd4, 1); mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        chk("ill_pulse", 64'(illegal_sel), 1);
        chk("ill_we", 64'(rf_we), 0);
        chk("ill_sel", 64'(sel_onehot), 0);
        req(1, 3'b000, 5'd0, 1); alu_result = 32'h55;
        tick();
        chk("ill_once", 64'(illegal_sel), 0);
        chk("rd0_we", 64'(rf_we), 0);
        chk("rd0_sel", 64'(sel_onehot), 64'b00001);

        // reset abandons a pending load
        req(1, 3'b001, 5'd9, 1);
        tick();
        req(0, 3'b000, 5'd0, 0); rst = 1;
        tick();
        chk("rst_ld_ready", 64'(in_ready), 0);
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 0;
        chk("rst_ld_no_we", 64'(rf_we), 0);
        chk("rst_ld_idle", 64'(in_ready), 1);

        if (TMO_EN) begin
            req(1, 3'b001, 5'd2, 1);
            tick();
            req(0, 3'b000, 5'd0, 0);
            for (int i = 1; i <= TMO; i++) begin
                tick();
                if (i < TMO) chk("tmo_quiet", 64'(mem_timeout), 0);
            end
            chk("tmo_pulse", 64'(mem_timeout), 1);
            chk("tmo_no_we", 64'(rf_we), 0);
            chk("tmo_ready", 64'(in_ready), 1);
            tick();
            chk("tmo_once", 64'(mem_timeout), 0);
            req(1, 3'b001, 5'd2, 1);
            tick();
            req(0, 3'b000, 5'd0, 0);
            for (int i = 1; i < TMO; i++) tick();
            mem_rvalid = 1; mem_rdata = 32'hCAFE_0016;
            tick();
            mem_rvalid = 0;
            chk("tmo_rv_we", 64'(rf_we), 1);
            chk("tmo_rv_wdata", 64'(rf_wdata), 64'hCAFE_0016);
            chk("tmo_rv_quiet", 64'(mem_timeout), 0);
        end

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            in_valid     = ($urandom_range(0, 9) < 7);
            in_sel       = 3'($urandom_range(0, 7));
            in_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            in_reg_write = ($urandom_range(0, 9) < 9);
            alu_result   = $urandom;
            pc_plus4     = $urandom;
            pc_plus_imm  = $urandom;
            imm          = $urandom;
            mem_rdata    = $urandom;
            mem_rvalid   = ($urandom_range(0, 9) < 3);
            tick();
        end
        rst = 0; in_valid = 0; mem_rvalid = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_sel_decode.md
WB_SEL_DECODE -- requirements
Module: wb_sel_decode

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: datapath width.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 16: the maximum number of WAIT_MEM cycles (range 2..255).
REQ-003 clk  input  1: the single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 in_valid  input  1: a writeback request is present.
REQ-006 in_ready  output  1: the block accepts a request this cycle.
REQ-007 in_sel  input  3: writeback select code; 100=IMM, 011=PC+IMM, 010=PC+4, 001=LOAD, 000=ALU.
REQ-008 in_rd  input  5: destination register.
REQ-009 in_reg_write  input  1: the instruction writes the register file.
REQ-010 alu_result, pc_plus4, pc_plus_imm, imm  input  XLEN each: candidate writeback sources.
REQ-011 mem_rdata  input  XLEN; mem_rvalid  input  1: load data return.
REQ-012 rf_we  output  1; rf_waddr  output  5; rf_wdata  output  XLEN: register-file write port.
REQ-013 sel_onehot  output  5: registered decoded source; bit4=IMM, bit3=PC+IMM, bit2=PC+4, bit1=LOAD, bit0=ALU.
REQ-014 illegal_sel  output  1: one-cycle pulse on codes 101/110/111.

Function
REQ-015 The FSM SHALL have two states, IDLE and WAIT_MEM; in_ready SHALL be 1 in IDLE and 0 in WAIT_MEM.
REQ-016 A request is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-017 On acceptance of a non-LOAD legal code, the block SHALL assert rf_we for exactly one cycle on the next cycle, with rf_wdata equal to the selected source as sampled at acceptance, and SHALL remain in IDLE.
REQ-018 Back-to-back non-LOAD requests SHALL sustain one write per cycle.
REQ-019 On acceptance of a LOAD request, the block SHALL enter WAIT_MEM, latch in_rd and in_reg_write, and ignore mem_rvalid on the acceptance cycle.
REQ-020 In WAIT_MEM, a cycle with mem_rvalid=1 SHALL capture mem_rdata and move to IDLE; rf_we SHALL pulse on the following cycle with that data.
REQ-021 In WAIT_MEM, in_valid SHALL be ignored and no request is lost; the upstream holds it.
REQ-022 rf_we SHALL be forced to 0 when the latched rd is 0 or reg_write is 0; sel_onehot still updates.
REQ-023 On an illegal code, the block SHALL set sel_onehot=00000, pulse illegal_sel on the next cycle, produce no write, and remain in IDLE.
REQ-024 In IDLE, mem_rvalid SHALL be ignored (stale return).
REQ-025 sel_onehot, rf_waddr and rf_wdata SHALL hold their last values when rf_we=0.

Reset
REQ-026 While rst=1: the state SHALL be IDLE; rf_we, illegal_sel, sel_onehot, rf_waddr and rf_wdata SHALL be 0; the timeout counter SHALL be 0.
REQ-027 Reset during WAIT_MEM SHALL abandon the load with no write, and a later mem_rvalid SHALL be ignored.
REQ-028 in_ready SHALL be 0 while rst=1.

Configuration
REQ-029 The macro WB_MEM_TIMEOUT_EN SHALL control the load timeout feature.
REQ-030 With WB_MEM_TIMEOUT_EN defined:
  - an 8-bit counter SHALL count the WAIT_MEM cycles;
  - when MEM_TIMEOUT cycles elapse without mem_rvalid, the block SHALL return to IDLE with no write;
  - output mem_timeout (1 bit) SHALL pulse for one cycle;
  - if mem_rvalid arrives on the expiry cycle, mem_rvalid SHALL win.
REQ-031 Without WB_MEM_TIMEOUT_EN: there SHALL be no counter and no mem_timeout port, and WAIT_MEM SHALL persist until mem_rvalid or reset.

Structure
REQ-032 Package wb_pkg SHALL hold:
  - the select-code constants (SEL_ALU..SEL_IMM);
  - the one-hot constants;
  - the state enum type;
  - the default MEM_TIMEOUT.
REQ-033 Sub-module wb_sel_onehot (combinational 3-to-5 decoder with illegal flag) SHALL be instantiated once; the FSM, the registers and the data mux stay in wb_sel_decode.

Verification
REQ-034 Accept in_sel=000, rd=5, alu_result=0x0000_1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, sel_onehot=00001.
REQ-035 Consecutive cycles with sel 100 (imm=0xFFFF_F000) then 010 (pc_plus4=0x104), rd=3 -> two consecutive rf_we pulses with data 0xFFFFF000 then 0x104, and in_ready constantly 1.
REQ-036 LOAD with rd=7, mem_rvalid after 3 cycles with 0xDEAD_BEEF -> in_ready=0 for 3 cycles; rf_we one cycle after rvalid with 0xDEADBEEF, sel_onehot=00010.
REQ-037 in_sel=110 -> illegal_sel pulses once, rf_we=0, sel_onehot=00000; in_sel=000 with rd=0 -> rf_we=0.
REQ-038 LOAD, then rst for 1 cycle during WAIT_MEM, then mem_rvalid -> no write, state IDLE, in_ready=1.
REQ-039 With WB_MEM_TIMEOUT_EN and MEM_TIMEOUT=16, LOAD with no mem_rvalid -> mem_timeout pulses after 16 WAIT_MEM cycles, no write; when rvalid falls on cycle 16 instead -> a write occurs and mem_timeout stays 0.
